acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer.sv | 148 ++++++++++++++
 tb/tb_acc_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Frame sequencer for a KxK convolution accelerator: resets the datapath, loads
// the kernel, streams IMG*IMG activations, drains outputs and flags count errors.
module acc_sequencer #(
  parameter int N         = 16,
  parameter int K         = 3,
  parameter int IMG       = 6,
  parameter int OUT_MAX   = 4,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             global_rst_n,
  input  logic             start,
  input  logic             w_valid,
  input  logic [N-1:0]     w_data,
  output logic             w_ready,
  input  logic             a_valid,
  input  logic [N-1:0]     a_data,
  output logic             a_ready,
  output logic             acc_rst,
  output logic             acc_ce,
  output logic [K*K*N-1:0] acc_weights,
  output logic [N-1:0]     acc_activation,
  input  logic             acc_valid_op,
  input  logic             acc_end_op,
  input  logic [N-1:0]     acc_data_out,
  output logic             o_valid,
  output logic [N-1:0]     o_data,
  output logic [7:0]       out_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, RST, LDW, STREAM, DRAIN, DONE} state_t;
  localparam int CW = 16;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] acnt;
  logic [CW-1:0] dcnt;
  logic          rcnt;
  logic          w_acc;
  logic          a_acc;
  logic          end_seen;
  logic [7:0]    out_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_acc    = w_valid & w_ready;
  assign a_acc    = a_valid & a_ready;
  assign end_seen = acc_ce & acc_end_op;
  assign o_valid  = acc_valid_op & ~acc_end_op & acc_ce & ((state == STREAM) || (state == DRAIN));
  assign o_data   = acc_data_out;
  // Count as it will stand after this cycle, so the DONE-entry check sees a final output.
  assign out_nxt  = o_valid ? sat_inc(out_cnt) : out_cnt;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state          <= IDLE;
      wcnt           <= '0;
      acnt           <= '0;
      dcnt           <= '0;
      rcnt           <= 1'b0;
      acc_rst        <= 1'b0;
      acc_ce         <= 1'b0;
      acc_weights    <= '0;
      acc_activation <= '0;
      w_ready        <= 1'b0;
      a_ready        <= 1'b0;
      out_cnt        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (o_valid) begin
        out_cnt <= sat_inc(out_cnt);
        if (out_cnt == 8'(OUT_MAX)) err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RST;
            busy    <= 1'b1;
            acc_rst <= 1'b1;
            rcnt    <= 1'b0;
            out_cnt <= '0;
            err     <= 1'b0;
            wcnt    <= '0;
            acnt    <= '0;
            dcnt    <= '0;
          end
        end
        RST: begin
          if (!rcnt) begin
            rcnt <= 1'b1;
          end else begin
            acc_rst <= 1'b0;
            w_ready <= 1'b1;
            state   <= LDW;
          end
        end
        LDW: begin
          if (w_acc) begin
            acc_weights <= {acc_weights[K*K*N-N-1:0], w_data};
            wcnt        <= wcnt + 1'b1;
            if (wcnt == CW'(K*K-1)) begin
              w_ready <= 1'b0;
              a_ready <= 1'b1;
              state   <= STREAM;
            end
          end
        end
        STREAM: begin
          acc_ce <= a_acc;
          if (a_acc) begin
            acc_activation <= a_data;
            acnt           <= acnt + 1'b1;
            if (acnt == CW'(IMG*IMG-1)) begin
              a_ready <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          acc_activation <= '0;
          if (end_seen || (dcnt == CW'(DRAIN_MAX-1))) begin
            acc_ce <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
            if (!end_seen || (out_nxt != 8'(OUT_MAX))) err <= 1'b1;
          end else begin
            acc_ce <= 1'b1;
            dcnt   <= dcnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomized bench for acc_sequencer: a frame-level reference model predicts
// kernel packing, accept counts, output counts, drain length and error flag.
module tb_acc_sequencer;
  localparam int N = 16, K = 3, IMG = 6, OUT_MAX = 4, DRAIN_MAX = 64;
  localparam int KK = K*K, NACT = IMG*IMG, WW = K*K*N;

  logic          clk = 1'b0;
  logic          global_rst_n = 1'b0;
  logic          start = 1'b0;
  logic          w_valid = 1'b0;
  logic [N-1:0]  w_data = '0;
  logic          a_valid = 1'b0;
  logic [N-1:0]  a_data = '0;
  logic          acc_valid_op = 1'b0;
  logic          acc_end_op = 1'b0;
  logic [N-1:0]  acc_data_out = '0;
  logic          w_ready, a_ready, acc_rst, acc_ce, o_valid, busy, done, err;
  logic [WW-1:0] acc_weights;
  logic [N-1:0]  acc_activation, o_data;
  logic [7:0]    out_cnt;

  acc_sequencer #(.N(N), .K(K), .IMG(IMG), .OUT_MAX(OUT_MAX), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .start(start),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .acc_rst(acc_rst), .acc_ce(acc_ce), .acc_weights(acc_weights),
    .acc_activation(acc_activation), .acc_valid_op(acc_valid_op),
    .acc_end_op(acc_end_op), .acc_data_out(acc_data_out),
    .o_valid(o_valid), .o_data(o_data), .out_cnt(out_cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle monitor: samples 1 time unit before each rising edge.
  int         m_wacc, m_aacc, m_rst_cyc, m_ov, m_done, m_ce_after;
  bit         m_prev_acc, m_prev_done, m_drain;
  logic [N-1:0] m_prev_data, m_last;

  initial begin
    m_wacc = 0; m_aacc = 0; m_rst_cyc = 0; m_ov = 0; m_done = 0; m_ce_after = 0;
    m_prev_acc = 0; m_prev_done = 0; m_drain = 0; m_prev_data = '0; m_last = '0;
    forever begin
      @(negedge clk); #4;
      if (!global_rst_n) begin
        m_prev_acc = 0; m_prev_done = 0; m_drain = 0; m_last = '0;
      end else begin
        if (start && !busy) begin
          m_wacc = 0; m_aacc = 0; m_rst_cyc = 0; m_ov = 0; m_done = 0; m_ce_after = 0;
          m_drain = 0;
        end
        if (acc_rst || acc_ce) check("rst_ce_excl", WW'(acc_rst & acc_ce), '0);
        if (acc_rst) m_rst_cyc++;
        if (m_prev_acc) begin
          check("ce_after_accept", WW'(acc_ce), WW'(1));
          check("act_word", WW'(acc_activation), WW'(m_prev_data));
        end else if (a_ready) begin
          check("ce_stall", WW'(acc_ce), '0);
          check("act_held", WW'(acc_activation), WW'(m_last));
        end else if (acc_ce) begin
          check("drain_act_zero", WW'(acc_activation), '0);
        end
        if (m_drain && acc_ce) m_ce_after++;
        if (o_valid) begin
          m_ov++;
          check("o_data", WW'(o_data), WW'(acc_data_out));
        end
        if (done) begin
          m_done++;
          check("done_one_cycle", WW'(m_prev_done), '0);
          m_drain = 0;
          m_last = '0;
        end
        if (w_valid && w_ready) m_wacc++;
        m_prev_acc = a_valid && a_ready;
        m_prev_data = a_data;
        if (m_prev_acc) begin
          m_aacc++;
          m_last = a_data;
          if (m_aacc == NACT) m_drain = 1;
        end
        m_prev_done = done;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_acc_rst"}, WW'(acc_rst), '0);
    check({tag, "_acc_ce"}, WW'(acc_ce), '0);
    check({tag, "_weights"}, acc_weights, '0);
    check({tag, "_act"}, WW'(acc_activation), '0);
    check({tag, "_w_ready"}, WW'(w_ready), '0);
    check({tag, "_a_ready"}, WW'(a_ready), '0);
    check({tag, "_out_cnt"}, WW'(out_cnt), '0);
    check({tag, "_busy"}, WW'(busy), '0);
    check({tag, "_done"}, WW'(done), '0);
    check({tag, "_err"}, WW'(err), '0);
  endtask

  // One whole frame. abort_at > 0 asserts reset after that many activations.
  task automatic run_frame(input bit seq_w, input int gap_mode, input int nv,
                           input bit timeout, input bit noise, input int abort_at);
    logic [N-1:0]  wv[KK];
    logic [WW-1:0] exp_w;
    int            wi, ai, cyc, lim;
    bit            seen, exp_err;
    exp_w = '0;
    for (int i = 0; i < KK; i++) begin
      wv[i] = seq_w ? N'(i + 1) : N'($urandom);
      exp_w[(KK-1-i)*N +: N] = wv[i];
    end
    exp_err = timeout || (nv != OUT_MAX);
    lim = (abort_at > 0) ? abort_at : NACT;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #4;
    check("start_busy", WW'(busy), WW'(1));
    check("start_err_clear", WW'(err), '0);
    check("start_cnt_clear", WW'(out_cnt), '0);
    @(negedge clk);

    wi = 0; cyc = 0;
    while (wi < KK && cyc < 100) begin
      w_valid = noise ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_data  = wv[wi];
      a_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      a_data  = N'($urandom);
      start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      if (w_valid && w_ready) wi++;
      cyc++;
      @(negedge clk);
    end
    check("w_load_bound", WW'(wi), WW'(KK));
    w_valid = 1'b0; a_valid = 1'b0; start = 1'b0;

    ai = 0; cyc = 0;
    while (ai < lim && cyc < 400) begin
      case (gap_mode)
        0:       a_valid = 1'b1;
        1:       a_valid = ((cyc % 2) == 0);
        default: a_valid = 1'($urandom_range(0, 1));
      endcase
      a_data  = N'($urandom);
      w_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      w_data  = N'($urandom);
      start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      if (a_valid && a_ready) ai++;
      cyc++;
      @(negedge clk);
    end
    check("a_load_bound", WW'(ai), WW'(lim));
    a_valid = 1'b0; w_valid = 1'b0; start = 1'b0;

    if (abort_at > 0) begin
      global_rst_n = 1'b0;
      #1;
      reset_checks("abort");
      repeat (3) @(negedge clk);
      global_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk); #4;
        check("abort_no_done", WW'(done), '0);
        check("abort_idle", WW'(busy), '0);
      end
      @(negedge clk);
    end else begin
      for (int i = 0; i < nv; i++) begin
        acc_valid_op = 1'b1;
        acc_data_out = N'($urandom);
        @(negedge clk);
      end
      acc_valid_op = 1'b0;
      acc_end_op   = !timeout;
      seen = 0; cyc = 0;
      while (!seen && cyc < DRAIN_MAX + 20) begin
        #4;
        seen = done;
        cyc++;
        if (!seen) @(negedge clk);
      end
      check("done_seen", WW'(seen), WW'(1));
      check("weights", acc_weights, exp_w);
      check("out_cnt", WW'(out_cnt), WW'(nv > 255 ? 255 : nv));
      check("err", WW'(err), WW'(exp_err));
      @(negedge clk);
      acc_end_op = 1'b0;
      #4;
      check("idle_busy", WW'(busy), '0);
      check("idle_done", WW'(done), '0);
      check("err_sticky", WW'(err), WW'(exp_err));
      check("weights_held", acc_weights, exp_w);
      check("out_cnt_held", WW'(out_cnt), WW'(nv));
      check("done_pulses", WW'(m_done), WW'(1));
      check("w_accepts", WW'(m_wacc), WW'(KK));
      check("a_accepts", WW'(m_aacc), WW'(NACT));
      check("rst_cycles", WW'(m_rst_cyc), WW'(2));
      check("o_valid_cnt", WW'(m_ov), WW'(nv));
      check("drain_ce", WW'(m_ce_after), WW'(timeout ? DRAIN_MAX : nv + 1));
      @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    global_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("por");
    global_rst_n = 1'b1;
    @(negedge clk);

    run_frame(1, 0, 4, 0, 0, 0);   // nominal kernel 1..9
    run_frame(1, 1, 4, 0, 0, 0);   // stalled stream
    run_frame(0, 0, 3, 0, 0, 0);   // short output count
    run_frame(0, 0, 2, 1, 0, 0);   // drain timeout
    run_frame(0, 0, 0, 0, 0, 10);  // reset mid-stream
    run_frame(1, 0, 4, 0, 0, 0);   // recovery
    run_frame(0, 2, 4, 0, 1, 0);   // stray starts/valids
    for (int f = 0; f < 4; f++)
      run_frame(0, $urandom_range(0, 2), $urandom_range(2, 6), 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
